processador_multiciclo: RTL and testbench

PROCESSADOR_MULTICICLO -- requirements
Module: processador_multiciclo

---
 rtl/processador_multiciclo.sv | 168 ++++++++++++++++
 tb/tb_processador_multiciclo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/processador_multiciclo.sv
// Multicycle register-file core: FETCH -> EXEC -> WB, plus a sticky HALT state.
// EXEC computes into holding registers; WB commits the register file, result and flags.
module processador_multiciclo #(
  parameter  int DATA_W  = 8,
  parameter  int NREGS   = 8,
  localparam int RA_W    = $clog2(NREGS),
  localparam int INSTR_W = 5 + 3 * RA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  in_data,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  result,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               sign_flag,
  output logic               parity_flag,
  output logic               overflow_flag,
  output logic               busy,
  output logic               halted
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_WB    = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_GT   = 5'd8;
  localparam logic [4:0] OP_LT   = 5'd9;
  localparam logic [4:0] OP_EQ   = 5'd10;
  localparam logic [4:0] OP_NE   = 5'd11;
  localparam logic [4:0] OP_MOV  = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_SHR  = 5'd14;
  localparam logic [4:0] OP_NOT  = 5'd15;
  localparam logic [4:0] OP_IN   = 5'd16;
  localparam logic [4:0] OP_OUT  = 5'd17;
  localparam logic [4:0] OP_HALT = 5'd18;

  logic [1:0]          state;
  logic [INSTR_W-1:0]  instr_p0;
  logic [4:0]          op_p0;
  logic [RA_W-1:0]     rd_p0, ra_p0, rb_p0;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [DATA_W-1:0]   a_p0, b_p0;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry, alu_ovf;
  logic [DATA_W-1:0]   res_p1;
  logic [4:0]          flags_p1;
  logic [4:0]          flags;

  // Flag vector order: {zero, carry, sign, parity(even), overflow}
  function automatic logic [4:0] pack_flags(input logic [DATA_W-1:0] r,
                                            input logic c, input logic v);
    return {(r == '0), c, r[DATA_W-1], ~^r, v};
  endfunction

  assign {op_p0, rd_p0, ra_p0, rb_p0} = instr_p0;
  assign a_p0 = regs[ra_p0];
  assign b_p0 = regs[rb_p0];

  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op_p0)
      OP_ADD: begin
        sum       = {1'b0, a_p0} + {1'b0, b_p0};
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
        alu_ovf   = (a_p0[DATA_W-1] == b_p0[DATA_W-1]) && (alu_res[DATA_W-1] != a_p0[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res   = a_p0 - b_p0;
        alu_carry = (a_p0 < b_p0);
        alu_ovf   = (a_p0[DATA_W-1] != b_p0[DATA_W-1]) && (alu_res[DATA_W-1] != a_p0[DATA_W-1]);
      end
      OP_MUL: alu_res = a_p0 * b_p0;
      // Divide by zero saturates to all ones and raises carry.
      OP_DIV: begin
        alu_carry = (b_p0 == '0);
        alu_res   = alu_carry ? '1 : a_p0 / b_p0;
      end
      OP_MOD: begin
        alu_carry = (b_p0 == '0);
        alu_res   = alu_carry ? '1 : a_p0 % b_p0;
      end
      OP_AND: alu_res = a_p0 & b_p0;
      OP_OR:  alu_res = a_p0 | b_p0;
      OP_XOR: alu_res = a_p0 ^ b_p0;
      OP_GT:  alu_res = {{(DATA_W-1){1'b0}}, (a_p0 > b_p0)};
      OP_LT:  alu_res = {{(DATA_W-1){1'b0}}, (a_p0 < b_p0)};
      OP_EQ:  alu_res = {{(DATA_W-1){1'b0}}, (a_p0 == b_p0)};
      OP_NE:  alu_res = {{(DATA_W-1){1'b0}}, (a_p0 != b_p0)};
      OP_MOV: alu_res = a_p0;
      OP_SHL: alu_res = {a_p0[DATA_W-2:0], 1'b0};
      OP_SHR: alu_res = {1'b0, a_p0[DATA_W-1:1]};
      OP_NOT: alu_res = ~a_p0;
      OP_IN:  alu_res = in_data;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      instr_p0  <= '0;
      res_p1    <= '0;
      flags_p1  <= '0;
      flags     <= '0;
      result    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        // p0: instruction capture
        S_FETCH: begin
          if (instr_valid) begin
            instr_p0 <= instr;
            state    <= S_EXEC;
          end
        end
        // p1: operands read, result and next flags held for commit
        S_EXEC: begin
          res_p1   <= alu_res;
          flags_p1 <= pack_flags(alu_res, alu_carry, alu_ovf);
          if (op_p0 == OP_OUT) begin
            out_data  <= a_p0;
            out_valid <= 1'b1;
          end
          state <= S_WB;
        end
        // p2: commit
        S_WB: begin
          if (op_p0 <= OP_IN) begin
            regs[rd_p0] <= res_p1;
            result      <= res_p1;
          end
          if (op_p0 <= OP_NOT) flags <= flags_p1;
          state <= (op_p0 == OP_HALT) ? S_HALT : S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  assign {zero_flag, carry_flag, sign_flag, parity_flag, overflow_flag} = flags;
  assign instr_ready = (state == S_FETCH);
  assign busy        = (state == S_EXEC) || (state == S_WB);
  assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_processador_multiciclo.sv
// Bench for processador_multiciclo: directed vector table, multicycle corner sequences,
// and random instruction streams checked against an arithmetic reference model.
module tb_processador_multiciclo;
  localparam int DATA_W  = 8;
  localparam int NREGS   = 8;
  localparam int RA_W    = $clog2(NREGS);
  localparam int INSTR_W = 5 + 3 * RA_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [DATA_W-1:0]  in_data;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic [DATA_W-1:0]  result;
  logic               zero_flag, carry_flag, sign_flag, parity_flag, overflow_flag;
  logic               busy, halted;

  int n_chk  = 0;
  int n_fail = 0;

  processador_multiciclo #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
    .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .sign_flag(sign_flag), .parity_flag(parity_flag), .overflow_flag(overflow_flag),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]        op;
    int                rd, ra, rb;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] exp_res;
    logic [4:0]        exp_flags;   // {zero, carry, sign, parity, overflow}
    bit                is_out;
    logic [DATA_W-1:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  longint     m_regs [NREGS];
  longint     m_res, m_out;
  logic [4:0] m_flags;

  function automatic vec_t mk(input int op, input int rd, input int ra, input int rb,
                              input int din, input int res, input int fl,
                              input bit is_out, input int od);
    vec_t v;
    v.op = 5'(op); v.rd = rd; v.ra = ra; v.rb = rb;
    v.din = DATA_W'(din); v.exp_res = DATA_W'(res); v.exp_flags = 5'(fl);
    v.is_out = is_out; v.exp_out = DATA_W'(od);
    return v;
  endfunction

  function automatic logic [4:0] dut_flags();
    return {zero_flag, carry_flag, sign_flag, parity_flag, overflow_flag};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
    m_res = 0; m_out = 0; m_flags = '0;
  endfunction

  function automatic void model_step(input int op, input int rd, input int ra, input int rb,
                                     input longint din);
    longint M, H, a, b, sa, sb, r, full;
    bit c, v;
    M = longint'(1) << DATA_W;
    H = M / 2;
    a = m_regs[ra]; b = m_regs[rb];
    sa = (a >= H) ? a - M : a;
    sb = (b >= H) ? b - M : b;
    r = 0; c = 0; v = 0; full = 0;
    case (op)
      0:  begin r = a + b; c = (r >= M); full = sa + sb; v = (full >= H) || (full < -H); end
      1:  begin r = a - b; c = (a < b);  full = sa - sb; v = (full >= H) || (full < -H); end
      2:  r = a * b;
      3:  if (b == 0) begin r = M - 1; c = 1; end else r = a / b;
      4:  if (b == 0) begin r = M - 1; c = 1; end else r = a % b;
      5:  r = a & b;
      6:  r = a | b;
      7:  r = a ^ b;
      8:  r = (a > b) ? 1 : 0;
      9:  r = (a < b) ? 1 : 0;
      10: r = (a == b) ? 1 : 0;
      11: r = (a != b) ? 1 : 0;
      12: r = a;
      13: r = a * 2;
      14: r = a / 2;
      15: r = M - 1 - a;
      16: r = din;
      default: r = 0;
    endcase
    r = ((r % M) + M) % M;
    if (op == 17) m_out = a;
    if (op <= 16) begin m_regs[rd] = r; m_res = r; end
    if (op <= 15)
      m_flags = {(r == 0), c, (((r >> (DATA_W-1)) & 1) != 0), (($countones(r) % 2) == 0), v};
  endfunction

  // Issues one instruction and samples ready/out_valid in the EXEC, WB and following cycles.
  task automatic run_instr(input int op, input int rd, input int ra, input int rb,
                           input logic [DATA_W-1:0] din, output bit ok,
                           output logic [2:0] rdy, output logic [2:0] ov,
                           output logic [DATA_W-1:0] od);
    int n;
    n = 0; ok = 0; rdy = '0; ov = '0; od = '0;
    while (instr_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (instr_ready !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: instr_ready=%b, expected 1", instr_ready);
      return;
    end
    instr = {5'(op), RA_W'(rd), RA_W'(ra), RA_W'(rb)};
    in_data = din;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    rdy[0] = instr_ready; ov[0] = out_valid;
    @(negedge clk);
    rdy[1] = instr_ready; ov[1] = out_valid; od = out_data;
    @(negedge clk);
    rdy[2] = instr_ready; ov[2] = out_valid;
    ok = 1;
  endtask

  task automatic do_reset();
    rst = 1'b1; instr_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit ok;
    logic [2:0] rdy, ov;
    logic [DATA_W-1:0] od;
    int op, rd, ra, rb;
    logic [DATA_W-1:0] din;

    rst = 1'b1; instr_valid = 1'b0; instr = '0; in_data = '0;
    do_reset();

    chk("reset_ready", instr_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_halted", halted, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", dut_flags(), 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);

    //          op rd ra rb din   res   flags    out od
    vecs.push_back(mk(16, 1, 0, 0, 200, 200,  5'b00000, 0, 0));
    vecs.push_back(mk(16, 2, 0, 0, 100, 100,  5'b00000, 0, 0));
    vecs.push_back(mk(0,  3, 1, 2, 0,   44,   5'b01000, 0, 0));
    vecs.push_back(mk(16, 1, 0, 0, 'h70, 'h70, 5'b01000, 0, 0));
    vecs.push_back(mk(16, 2, 0, 0, 'h20, 'h20, 5'b01000, 0, 0));
    vecs.push_back(mk(0,  3, 1, 2, 0, 'h90, 5'b00111, 0, 0));
    vecs.push_back(mk(1,  3, 2, 1, 0, 'hB0, 5'b01100, 0, 0));
    vecs.push_back(mk(3,  3, 1, 0, 0, 'hFF, 5'b01110, 0, 0));
    vecs.push_back(mk(4,  4, 1, 0, 0, 'hFF, 5'b01110, 0, 0));
    vecs.push_back(mk(16, 1, 0, 0, 'h5A, 'h5A, 5'b01110, 0, 0));
    vecs.push_back(mk(17, 0, 1, 0, 0, 'h5A, 5'b01110, 1, 'h5A));
    vecs.push_back(mk(2,  5, 1, 1, 0, 'hA4, 5'b00100, 0, 0));
    vecs.push_back(mk(8,  6, 1, 5, 0, 0,    5'b10010, 0, 0));
    vecs.push_back(mk(9,  6, 1, 5, 0, 1,    5'b00000, 0, 0));
    vecs.push_back(mk(10, 7, 1, 1, 0, 1,    5'b00000, 0, 0));
    vecs.push_back(mk(11, 7, 1, 1, 0, 0,    5'b10010, 0, 0));
    vecs.push_back(mk(19, 7, 1, 1, 0, 0,    5'b10010, 0, 0));
    vecs.push_back(mk(5,  2, 1, 5, 0, 0,    5'b10010, 0, 0));
    vecs.push_back(mk(6,  2, 1, 5, 0, 'hFE, 5'b00100, 0, 0));
    vecs.push_back(mk(7,  2, 1, 5, 0, 'hFE, 5'b00100, 0, 0));
    vecs.push_back(mk(13, 3, 1, 0, 0, 'hB4, 5'b00110, 0, 0));
    vecs.push_back(mk(14, 3, 1, 0, 0, 'h2D, 5'b00010, 0, 0));
    vecs.push_back(mk(15, 3, 1, 0, 0, 'hA5, 5'b00110, 0, 0));
    vecs.push_back(mk(12, 3, 5, 0, 0, 'hA4, 5'b00100, 0, 0));
    vecs.push_back(mk(17, 0, 3, 0, 0, 'hA4, 5'b00100, 1, 'hA4));
    vecs.push_back(mk(0,  1, 1, 1, 0, 'hB4, 5'b00111, 0, 0));
    vecs.push_back(mk(17, 0, 1, 0, 0, 'hB4, 5'b00111, 1, 'hB4));

    for (int i = 0; i < vecs.size(); i++) begin
      run_instr(vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb, vecs[i].din, ok, rdy, ov, od);
      if (ok) begin
        chk($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
        chk($sformatf("vec%0d_flags", i), dut_flags(), vecs[i].exp_flags);
        chk($sformatf("vec%0d_ready_latency", i), rdy, 3'b100);
        chk($sformatf("vec%0d_out_pulse", i), ov, vecs[i].is_out ? 3'b010 : 3'b000);
        if (vecs[i].is_out) chk($sformatf("vec%0d_out_data", i), od, vecs[i].exp_out);
      end
    end

    // HALT holds against instr_valid until reset, which clears the register file
    run_instr(18, 0, 0, 0, '0, ok, rdy, ov, od);
    if (ok) begin
      chk("halt_ready_seq", rdy, 3'b000);
      chk("halt_halted", halted, 1);
      chk("halt_busy", busy, 0);
      chk("halt_result", result, 'hB4);
    end
    instr = {5'd16, RA_W'(2), RA_W'(0), RA_W'(0)};
    in_data = 'h11;
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("halt_hold_ready%0d", i), instr_ready, 0);
      chk($sformatf("halt_hold_halted%0d", i), halted, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b0;
    chk("post_halt_ready", instr_ready, 1);
    chk("post_halt_halted", halted, 0);
    chk("post_halt_result", result, 0);
    chk("post_halt_flags", dut_flags(), 0);
    run_instr(12, 2, 1, 0, '0, ok, rdy, ov, od);
    if (ok) begin
      chk("post_halt_r1_cleared", result, 0);
      chk("post_halt_mov_flags", dut_flags(), 5'b10010);
    end

    // Load a nonzero result, then abandon IN r4 in EXEC via reset
    run_instr(16, 6, 0, 0, 'h42, ok, rdy, ov, od);
    if (ok) chk("pre_abort_result", result, 'h42);
    chk("abort_start_ready", instr_ready, 1);
    instr = {5'd16, RA_W'(4), RA_W'(0), RA_W'(0)};
    in_data = 'h33;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("abort_in_exec_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready_after_rst", instr_ready, 1);
    chk("abort_busy_after_rst", busy, 0);
    @(negedge clk);
    chk("abort_no_writeback_result", result, 0);
    run_instr(12, 5, 4, 0, '0, ok, rdy, ov, od);
    if (ok) chk("abort_r4_stays_zero", result, 0);

    // Random instruction stream against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 31);
      if (op == 18) op = 19;
      if (i < 40) op = (i % 3 == 0) ? 16 : op;
      rd = $urandom_range(0, NREGS-1);
      ra = $urandom_range(0, NREGS-1);
      rb = $urandom_range(0, NREGS-1);
      case ($urandom_range(0, 4))
        0: din = '0;
        1: din = '1;
        2: din = {1'b1, {(DATA_W-1){1'b0}}};
        default: din = DATA_W'($urandom);
      endcase
      run_instr(op, rd, ra, rb, din, ok, rdy, ov, od);
      model_step(op, rd, ra, rb, longint'(din));
      if (ok) begin
        chk($sformatf("rnd%0d_op%0d_result", i, op), result, m_res);
        chk($sformatf("rnd%0d_op%0d_flags", i, op), dut_flags(), m_flags);
        chk($sformatf("rnd%0d_op%0d_out_pulse", i, op), ov, (op == 17) ? 3'b010 : 3'b000);
        if (op == 17) chk($sformatf("rnd%0d_out_data", i), od, m_out);
        else          chk($sformatf("rnd%0d_out_hold", i), out_data, m_out);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
